// File: rtl/reg_file_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_arbiter_pkg
//   Shared definitions for the reg_file arbiter: owner encoding and the
//   default widths used by the arbiter top level.
// ---------------------------------------------------------------------------
package reg_file_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 16;

    // Owner tag carried down the pipeline with every accepted command.
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/reg_file_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter, purely combinational.
//   Ports:
//     req   [1:0]  request vector, bit 0 = client A, bit 1 = client B
//     last         owner that won the previous accepted contest
//     grant [1:0]  one-hot grant, or zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2
    import reg_file_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contest: the client that did not win last time goes first.
            2'b11:   grant = (last == OWNER_B) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// ---------------------------------------------------------------------------
// reg_file_arbiter
//   Shares one reg_file (2 combinational read ports, 1 write port) between
//   clients A and B. Round-robin arbitration, accept stage in the handshake
//   cycle N, issue stage register driving the reg_file in N+1, response
//   strobe in N+2.
//
//   Handshake: a request transfers on a cycle where x_valid & x_ready are
//   both high at the rising edge; the requester keeps its fields stable while
//   x_valid is high and x_ready is low. Responses have no backpressure.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     a_valid/a_ready          client A request handshake
//     a_rs1/a_rs2/a_rd         client A register indices
//     a_we/a_wdata             client A write enable and data
//     a_rsp_valid              client A one-cycle response strobe
//     a_rv1/a_rv2              client A read data, held until next response
//     b_*                      same set for client B
//     rf_rs1/rf_rs2/rf_rd      reg_file indices
//     rf_we/rf_indata          reg_file write enable and data
//     rf_rv1/rf_rv2            reg_file combinational read data
//     a_grants/b_grants        saturating accepted-request counters
// ---------------------------------------------------------------------------
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rs1,
    input  logic [ADDR_W-1:0] a_rs2,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rv1,
    output logic [DATA_W-1:0] a_rv2,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rs1,
    input  logic [ADDR_W-1:0] b_rs2,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rv1,
    output logic [DATA_W-1:0] b_rv2,

    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic [ADDR_W-1:0] rf_rd,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_indata,
    input  logic [DATA_W-1:0] rf_rv1,
    input  logic [DATA_W-1:0] rf_rv2,

    output logic [CNT_W-1:0]  a_grants,
    output logic [CNT_W-1:0]  b_grants
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              last_grant;
    logic [1:0]        grant;
    logic              fire_a;
    logic              fire_b;

    // Accept stage: the winning request as seen in the handshake cycle.
    logic              acc_v;
    logic              acc_owner;
    logic [ADDR_W-1:0] acc_rs1;
    logic [ADDR_W-1:0] acc_rs2;
    logic [ADDR_W-1:0] acc_rd;
    logic              acc_we;
    logic [DATA_W-1:0] acc_wdata;

    // Issue stage: the command currently presented to the reg_file.
    logic              iss_v;
    logic              iss_owner;
    logic [ADDR_W-1:0] iss_rs1;
    logic [ADDR_W-1:0] iss_rs2;
    logic [ADDR_W-1:0] iss_rd;
    logic              iss_we;
    logic [DATA_W-1:0] iss_wdata;

    rr_arb2 u_arb (
        .req   ({b_valid, a_valid}),
        .last  (last_grant),
        .grant (grant)
    );

    assign a_ready = grant[0] & ~rst;
    assign b_ready = grant[1] & ~rst;
    assign fire_a  = a_valid & a_ready;
    assign fire_b  = b_valid & b_ready;

    always_comb begin
        acc_v     = fire_a | fire_b;
        acc_owner = OWNER_A;
        acc_rs1   = a_rs1;
        acc_rs2   = a_rs2;
        acc_rd    = a_rd;
        acc_we    = a_we;
        acc_wdata = a_wdata;
        if (fire_b) begin
            acc_owner = OWNER_B;
            acc_rs1   = b_rs1;
            acc_rs2   = b_rs2;
            acc_rd    = b_rd;
            acc_we    = b_we;
            acc_wdata = b_wdata;
        end
    end

    // Accept -> issue register, round-robin pointer and grant counters.
    // Issue fields only load on a valid command so the reg_file address and
    // data lines hold their last values while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWNER_B;
            iss_v      <= 1'b0;
            iss_owner  <= OWNER_A;
            iss_rs1    <= '0;
            iss_rs2    <= '0;
            iss_rd     <= '0;
            iss_we     <= 1'b0;
            iss_wdata  <= '0;
            a_grants   <= '0;
            b_grants   <= '0;
        end else begin
            iss_v <= acc_v;
            if (acc_v) begin
                iss_owner  <= acc_owner;
                iss_rs1    <= acc_rs1;
                iss_rs2    <= acc_rs2;
                iss_rd     <= acc_rd;
                iss_we     <= acc_we;
                iss_wdata  <= acc_wdata;
                last_grant <= acc_owner;
                if (acc_owner == OWNER_A) begin
                    if (a_grants != CNT_MAX) a_grants <= a_grants + CNT_W'(1);
                end else begin
                    if (b_grants != CNT_MAX) b_grants <= b_grants + CNT_W'(1);
                end
            end
        end
    end

    assign rf_rs1    = iss_rs1;
    assign rf_rs2    = iss_rs2;
    assign rf_rd     = iss_rd;
    assign rf_indata = iss_wdata;
    // Reset kills the write in the same cycle, not just at the next edge.
    assign rf_we     = iss_v & iss_we & ~rst;

    // Response registers: read data is sampled at the end of the issue cycle,
    // before the command's own write lands, and only the owner's copy moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rv1       <= '0;
            a_rv2       <= '0;
            b_rv1       <= '0;
            b_rv2       <= '0;
        end else begin
            a_rsp_valid <= iss_v & (iss_owner == OWNER_A);
            b_rsp_valid <= iss_v & (iss_owner == OWNER_B);
            if (iss_v && iss_owner == OWNER_A) begin
                a_rv1 <= rf_rv1;
                a_rv2 <= rf_rv2;
            end
            if (iss_v && iss_owner == OWNER_B) begin
                b_rv1 <= rf_rv1;
                b_rv2 <= rf_rv2;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_file_arbiter
//   Drives reg_file_arbiter (CNT_W=4) against a behavioural reg_file and a
//   reference model in which every accepted command reads then writes a
//   register array in acceptance order, with its response due two cycles
//   after acceptance.
// ---------------------------------------------------------------------------
module tb_reg_file_arbiter;
    import reg_file_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    logic          a_we, b_we;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rv1, a_rv2, b_rv1, b_rv2;
    logic [AW-1:0] rf_rs1, rf_rs2, rf_rd;
    logic          rf_we;
    logic [DW-1:0] rf_indata, rf_rv1, rf_rv2;
    logic [CW-1:0] a_grants, b_grants;

    reg_file_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rs1(a_rs1), .a_rs2(a_rs2),
        .a_rd(a_rd), .a_we(a_we), .a_wdata(a_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rv1(a_rv1), .a_rv2(a_rv2),
        .b_valid(b_valid), .b_ready(b_ready), .b_rs1(b_rs1), .b_rs2(b_rs2),
        .b_rd(b_rd), .b_we(b_we), .b_wdata(b_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rv1(b_rv1), .b_rv2(b_rv2),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_we(rf_we),
        .rf_indata(rf_indata), .rf_rv1(rf_rv1), .rf_rv2(rf_rv2),
        .a_grants(a_grants), .b_grants(b_grants)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reg_file ----------------
    logic          rf_init;
    logic [DW-1:0] rf_mem [32];

    function automatic logic [DW-1:0] pat(input int i);
        return (DW'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= pat(i);
        end else if (rf_we) begin
            rf_mem[rf_rd] <= rf_indata;
        end
    end
    assign rf_rv1 = rf_mem[rf_rs1];
    assign rf_rv2 = rf_mem[rf_rs2];

    // ---------------- reference model ----------------
    typedef struct {
        logic          owner;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          we;
        logic [DW-1:0] wdata;
        int            due;
    } cmd_t;

    cmd_t          pend_q[$];
    logic [DW-1:0] ref_regs [32];
    logic          m_last;
    int            m_cnt_a, m_cnt_b;
    logic [DW-1:0] m_a_rv1, m_a_rv2, m_b_rv1, m_b_rv2;
    logic          a_acc_last, b_acc_last;
    int            cyc;
    int            checks, errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        m_last  = OWNER_B;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_a_rv1 = '0; m_a_rv2 = '0; m_b_rv1 = '0; m_b_rv2 = '0;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model,
    // then return just after the next rising edge so the caller can drive.
    task automatic tick();
        logic exp_ga, exp_gb, exp_ars, exp_brs, exp_we;
        logic [AW-1:0] exp_rd;
        logic [DW-1:0] exp_wd;
        cmd_t c;
        @(negedge clk);
        exp_ga = !rst && a_valid && (!b_valid || m_last == OWNER_B);
        exp_gb = !rst && b_valid && (!a_valid || m_last == OWNER_A);
        chk("a_ready", a_ready, exp_ga);
        chk("b_ready", b_ready, exp_gb);

        exp_we = 1'b0; exp_rd = '0; exp_wd = '0;
        foreach (pend_q[i]) begin
            if (pend_q[i].due == cyc + 1) begin
                exp_we = pend_q[i].we && !rst;
                exp_rd = pend_q[i].rd;
                exp_wd = pend_q[i].wdata;
            end
        end
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk("rf_rd", rf_rd, exp_rd);
            chk("rf_indata", rf_indata, exp_wd);
        end

        exp_ars = 1'b0; exp_brs = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            c = pend_q.pop_front();
            if (c.owner == OWNER_A) begin
                exp_ars = 1'b1;
                m_a_rv1 = ref_regs[c.rs1];
                m_a_rv2 = ref_regs[c.rs2];
            end else begin
                exp_brs = 1'b1;
                m_b_rv1 = ref_regs[c.rs1];
                m_b_rv2 = ref_regs[c.rs2];
            end
            if (c.we) ref_regs[c.rd] = c.wdata;
        end
        chk("a_rsp_valid", a_rsp_valid, exp_ars);
        chk("b_rsp_valid", b_rsp_valid, exp_brs);
        chk("a_rv1", a_rv1, m_a_rv1);
        chk("a_rv2", a_rv2, m_a_rv2);
        chk("b_rv1", b_rv1, m_b_rv1);
        chk("b_rv2", b_rv2, m_b_rv2);
        chk("a_grants", a_grants, m_cnt_a);
        chk("b_grants", b_grants, m_cnt_b);

        a_acc_last = a_valid && exp_ga;
        b_acc_last = b_valid && exp_gb;
        if (a_acc_last) begin
            pend_q.push_back('{OWNER_A, a_rs1, a_rs2, a_rd, a_we, a_wdata, cyc + 2});
            m_last = OWNER_A;
            if (m_cnt_a < CNT_SAT) m_cnt_a++;
        end
        if (b_acc_last) begin
            pend_q.push_back('{OWNER_B, b_rs1, b_rs2, b_rd, b_we, b_wdata, cyc + 2});
            m_last = OWNER_B;
            if (m_cnt_b < CNT_SAT) m_cnt_b++;
        end
        if (rst) model_reset();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic set_a(input logic v, input int rs1, input int rs2, input int rd,
                         input logic we, input logic [DW-1:0] wd);
        a_valid = v; a_rs1 = AW'(rs1); a_rs2 = AW'(rs2); a_rd = AW'(rd);
        a_we = we; a_wdata = wd;
    endtask

    task automatic set_b(input logic v, input int rs1, input int rs2, input int rd,
                         input logic we, input logic [DW-1:0] wd);
        b_valid = v; b_rs1 = AW'(rs1); b_rs2 = AW'(rs2); b_rd = AW'(rd);
        b_we = we; b_wdata = wd;
    endtask

    // Randomise a client only when it is free to change its request.
    task automatic rand_a(input int pct);
        if (a_valid && !a_acc_last) return;
        set_a($urandom_range(99) < pct, $urandom_range(31), $urandom_range(31),
              $urandom_range(31), 1'($urandom_range(1)), $urandom);
    endtask

    task automatic rand_b(input int pct);
        if (b_valid && !b_acc_last) return;
        set_b($urandom_range(99) < pct, $urandom_range(31), $urandom_range(31),
              $urandom_range(31), 1'($urandom_range(1)), $urandom);
    endtask

    task automatic do_reset();
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        set_b(1'b0, 0, 0, 0, 1'b0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int a_wait;
        int a_done;
        checks = 0; errors = 0; cyc = 0;
        a_acc_last = 1'b0; b_acc_last = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = pat(i);
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        set_b(1'b0, 0, 0, 0, 1'b0, '0);
        rst = 1'b1; rf_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rf_init = 1'b0;
        rst = 1'b0;
        model_reset();

        // reset state
        @(negedge clk);
        chk("rst_rf_rs1", rf_rs1, 0);
        chk("rst_rf_rs2", rf_rs2, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_indata", rf_indata, 0);
        chk("rst_rf_we", rf_we, 0);
        @(posedge clk);
        #1;
        cyc++;

        // 1: write r3 while reading old r3/r4, then read r3 back
        set_a(1'b1, 3, 4, 3, 1'b1, 32'hDEAD_BEEF);
        tick();
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        tick();
        tick();
        chk("t1_old_r3", a_rv1, pat(3));
        chk("t1_old_r4", a_rv2, pat(4));
        set_a(1'b1, 3, 3, 0, 1'b0, '0);
        tick();
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        tick();
        tick();
        chk("t1_new_r3", a_rv1, 32'hDEAD_BEEF);

        // 2: both clients contend for 6 cycles
        do_reset();
        set_a(1'b1, 1, 2, 0, 1'b0, '0);
        set_b(1'b1, 5, 6, 0, 1'b0, '0);
        repeat (6) tick();
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        set_b(1'b0, 0, 0, 0, 1'b0, '0);
        repeat (3) tick();
        chk("t2_a_grants", a_grants, 3);
        chk("t2_b_grants", b_grants, 3);

        // 3: B writes r7, A reads r7 on the very next cycle
        set_b(1'b1, 0, 0, 7, 1'b1, 32'h0000_1234);
        tick();
        set_b(1'b0, 0, 0, 0, 1'b0, '0);
        set_a(1'b1, 7, 7, 0, 1'b0, '0);
        tick();
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        tick();
        tick();
        chk("t3_a_r7", a_rv1, 32'h0000_1234);

        // 4: reset lands while a write is in the issue stage
        do_reset();
        set_a(1'b1, 9, 9, 9, 1'b1, 32'hCAFE_0009);
        tick();
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t4_r9_kept", rf_mem[9], ref_regs[9]);
        chk("t4_rf_rd", rf_rd, 0);
        chk("t4_rf_indata", rf_indata, 0);
        chk("t4_a_rv1", a_rv1, 0);

        // 5: counter saturation, B alone for 2^CW+2 accepts
        do_reset();
        set_b(1'b1, 2, 3, 0, 1'b0, '0);
        repeat (CNT_SAT + 3) tick();
        set_b(1'b0, 0, 0, 0, 1'b0, '0);
        repeat (2) tick();
        chk("t5_b_sat", b_grants, CNT_SAT);
        chk("t5_a_zero", a_grants, 0);

        // 6: A raises a request into a B stream and must win within a cycle
        do_reset();
        set_b(1'b1, 1, 1, 10, 1'b1, 32'h0B0B_0001);
        repeat (3) begin
            tick();
            rand_b(100);
        end
        set_a(1'b1, 10, 11, 11, 1'b1, 32'hA5A5_0006);
        a_wait = 0;
        a_done = 0;
        for (int i = 0; i < 8 && a_done == 0; i++) begin
            tick();
            if (a_acc_last) a_done = 1;
            else a_wait++;
            rand_b(100);
        end
        chk("t6_a_accepted", a_done, 1);
        chk("t6_a_wait_le1", (a_wait <= 1), 1);
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        set_b(1'b0, 0, 0, 0, 1'b0, '0);
        repeat (3) tick();

        // random traffic with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            rand_a(60);
            rand_b(60);
            if (i == 200) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                a_acc_last = 1'b1;
                b_acc_last = 1'b1;
            end else begin
                tick();
            end
        end
        set_a(1'b0, 0, 0, 0, 1'b0, '0);
        set_b(1'b0, 0, 0, 0, 1'b0, '0);
        repeat (3) tick();
        chk("end_queue_empty", pend_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
